// File: rtl/seg_scan_pkg.sv
// Shared constants for the multiplexed 7-segment scan controller:
// BCD nibble width, active-low anode levels and the scan-index width helper.
package seg_scan_pkg;

  localparam int   BCD_W  = 4;
  localparam logic AN_ON  = 1'b0;
  localparam logic AN_OFF = 1'b1;

  // A 2-digit display still needs one index bit.
  function automatic int idx_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Slot timer: counts 0..REFRESH_DIV-1 per digit slot. slot_end marks the last cycle of a slot;
// blank_phase reports whether the cycle entered at the next edge lies in the blanking gap.
module scan_tick_gen #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  output logic slot_end,
  output logic blank_phase
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // blank_phase looks one cycle ahead so the parent can register its anode outputs.
  always_comb begin
    slot_end    = (cnt_q == CNT_W'(REFRESH_DIV - 1));
    cnt_d       = slot_end ? '0 : cnt_q + 1'b1;
    blank_phase = (32'(cnt_d) < 32'(BLANK_CYCLES));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan of NUM_DIGITS common-anode digits through one shared BCD decoder, with a
// double-buffered digit word committed at frame wrap. Optional macro: LEADING_ZERO_BLANK_EN.
module seg_scan_ctrl
  import seg_scan_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en,
  input  logic                           load_valid,
  output logic                           load_ready,
  input  logic [BCD_W*NUM_DIGITS-1:0]    digits_in,
  output logic [BCD_W-1:0]               bcd_out,
  output logic [NUM_DIGITS-1:0]          an_n,
  output logic [idx_w(NUM_DIGITS)-1:0]   digit_idx,
  output logic                           frame_start
);

  localparam int               IDX_W    = idx_w(NUM_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

  typedef logic [NUM_DIGITS-1:0][BCD_W-1:0] word_t;

  word_t                 shadow_q, shadow_d;
  word_t                 active_q, active_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  pending_q, pending_d;
  logic                  load_ready_q, load_ready_d;
  logic                  frame_start_q, frame_start_d;
  logic [BCD_W-1:0]      bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0] an_n_q, an_n_d;
  logic [NUM_DIGITS-1:0] lit_mask;
  logic                  slot_end, blank_phase, wrap, accept;
`ifdef LEADING_ZERO_BLANK_EN
  logic                  upper_zero;
`endif

  scan_tick_gen #(
    .REFRESH_DIV  (REFRESH_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_tick (
    .clk         (clk),
    .rst         (rst),
    .slot_end    (slot_end),
    .blank_phase (blank_phase)
  );

  // Outputs are computed from next-state values so each registered output lines up with its slot.
  always_comb begin
    wrap   = slot_end && (idx_q == LAST_IDX);
    accept = load_valid && !pending_q;

    idx_d = idx_q;
    if (slot_end) begin
      idx_d = wrap ? '0 : idx_q + 1'b1;
    end

    shadow_d  = shadow_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (wrap && pending_q) begin
      active_d  = shadow_q;
      pending_d = 1'b0;
    end
    if (accept) begin
      shadow_d  = digits_in;
      pending_d = 1'b1;
    end

    load_ready_d  = !pending_d;
    frame_start_d = wrap;
    bcd_d         = active_d[idx_d];

    lit_mask = '1;
`ifdef LEADING_ZERO_BLANK_EN
    // Digit 0 is never suppressed, so a zero value still shows one "0".
    upper_zero = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      upper_zero = upper_zero && (active_d[i] == '0);
      if (upper_zero) begin
        lit_mask[i] = 1'b0;
      end
    end
`endif

    an_n_d = {NUM_DIGITS{AN_OFF}};
    if (en && !blank_phase && lit_mask[idx_d]) begin
      an_n_d[idx_d] = AN_ON;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q         <= '0;
      shadow_q      <= '0;
      active_q      <= '0;
      pending_q     <= 1'b0;
      load_ready_q  <= 1'b1;
      frame_start_q <= 1'b0;
      bcd_q         <= '0;
      an_n_q        <= {NUM_DIGITS{AN_OFF}};
    end else begin
      idx_q         <= idx_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      pending_q     <= pending_d;
      load_ready_q  <= load_ready_d;
      frame_start_q <= frame_start_d;
      bcd_q         <= bcd_d;
      an_n_q        <= an_n_d;
    end
  end

  assign load_ready  = load_ready_q;
  assign frame_start = frame_start_q;
  assign bcd_out     = bcd_q;
  assign an_n        = an_n_q;
  assign digit_idx   = idx_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl with NUM_DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_seg_scan_ctrl;

  localparam int N = 4;
  localparam int R = 8;
  localparam int B = 2;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, en, load_valid, load_ready, frame_start;
  logic [15:0] digits_in;
  logic [3:0]  bcd_out, an_n;
  logic [1:0]  digit_idx;

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .NUM_DIGITS   (N),
    .REFRESH_DIV  (R),
    .BLANK_CYCLES (B)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .digits_in   (digits_in),
    .bcd_out     (bcd_out),
    .an_n        (an_n),
    .digit_idx   (digit_idx),
    .frame_start (frame_start)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] bcd;
    logic [1:0] idx;
    logic       rdy;
    logic       fs;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t exp;
  } vec_t;

  obs_t sb[$];
  vec_t tab[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;

  int          m_cnt, m_idx;
  bit          m_pend;
  logic [15:0] m_sh, m_act;

  function automatic vec_t mk(int c, logic [3:0] an, logic [3:0] bcd, logic [1:0] idx,
                              logic rdy, logic fs);
    vec_t v;
    v.cyc = c;
    v.exp = '{an: an, bcd: bcd, idx: idx, rdy: rdy, fs: fs};
    return v;
  endfunction

  function automatic obs_t dut_obs();
    return obs_t'({an_n, bcd_out, digit_idx, load_ready, frame_start});
  endfunction

  task automatic cmp_obs(string name, obs_t g, obs_t e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s cyc=%0d: got an=%b bcd=%0d idx=%0d rdy=%b fs=%b, expected an=%b bcd=%0d idx=%0d rdy=%b fs=%b",
               name, cyc, g.an, g.bcd, g.idx, g.rdy, g.fs, e.an, e.bcd, e.idx, e.rdy, e.fs);
    end
  endtask

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Reference model: advances one clock from the inputs currently driven and queues what the
  // DUT must show in the following cycle.
  task automatic model_step();
    obs_t e;
    bit   acc, wr, lit;
    e = '0;
    if (rst) begin
      m_cnt = 0; m_idx = 0; m_pend = 0; m_sh = '0; m_act = '0;
    end else begin
      acc  = load_valid && !m_pend;
      wr   = (m_cnt == R - 1) && (m_idx == N - 1);
      e.fs = wr;
      if (wr && m_pend) begin
        m_act  = m_sh;
        m_pend = 0;
      end
      if (acc) begin
        m_sh   = digits_in;
        m_pend = 1;
      end
      if (m_cnt == R - 1) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % N;
      end else begin
        m_cnt++;
      end
    end
    lit   = !LZB || (m_idx == 0) || ((m_act >> (4 * m_idx)) != 16'h0);
    e.idx = 2'(m_idx);
    e.rdy = !m_pend;
    e.bcd = m_act[m_idx*4 +: 4];
    e.an  = 4'hF;
    if (!rst && en && (m_cnt >= B) && lit) e.an[m_idx] = 1'b0;
    sb.push_back(e);
  endtask

  task automatic step();
    obs_t e;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty cyc=%0d: got 0 entries expected 1", cyc);
    end else begin
      e = sb.pop_front();
      cmp_obs("scoreboard", dut_obs(), e);
    end
  endtask

  task automatic idle_to(int t);
    load_valid = 1'b0;
    while (cyc < t) step();
  endtask

  task automatic load1(logic [15:0] w);
    load_valid = 1'b1;
    digits_in  = w;
    step();
    load_valid = 1'b0;
  endtask

  task automatic load_hold(logic [15:0] w);
    int n;
    n = 0;
    load_valid = 1'b1;
    digits_in  = w;
    while (!load_ready && n < 100) begin
      step();
      n++;
    end
    chk("load_hold_ready", int'(load_ready), 1);
    step();
    load_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    en         = 1'b1;
    load_valid = 1'b0;
    digits_in  = '0;
    step();
    step();
    rst = 1'b0;
    cyc = 0;

    // Reset, idle scan, load 4321 at cycle 3 and its display in frame 2.
    tab.push_back(mk( 0, 4'b1111, 4'd0, 2'd0, 1'b1, 1'b0));
    tab.push_back(mk( 1, 4'b1111, 4'd0, 2'd0, 1'b1, 1'b0));
    tab.push_back(mk( 2, 4'b1110, 4'd0, 2'd0, 1'b1, 1'b0));
    tab.push_back(mk( 4, 4'b1110, 4'd0, 2'd0, 1'b0, 1'b0));
    tab.push_back(mk( 7, 4'b1110, 4'd0, 2'd0, 1'b0, 1'b0));
    tab.push_back(mk( 8, 4'b1111, 4'd0, 2'd1, 1'b0, 1'b0));
    tab.push_back(mk(10, LZB ? 4'b1111 : 4'b1101, 4'd0, 2'd1, 1'b0, 1'b0));
    tab.push_back(mk(31, LZB ? 4'b1111 : 4'b0111, 4'd0, 2'd3, 1'b0, 1'b0));
    tab.push_back(mk(32, 4'b1111, 4'd1, 2'd0, 1'b1, 1'b1));
    tab.push_back(mk(33, 4'b1111, 4'd1, 2'd0, 1'b1, 1'b0));
    tab.push_back(mk(34, 4'b1110, 4'd1, 2'd0, 1'b1, 1'b0));
    tab.push_back(mk(42, 4'b1101, 4'd2, 2'd1, 1'b1, 1'b0));
    tab.push_back(mk(50, 4'b1011, 4'd3, 2'd2, 1'b1, 1'b0));
    tab.push_back(mk(58, 4'b0111, 4'd4, 2'd3, 1'b1, 1'b0));
    tab.push_back(mk(64, 4'b1111, 4'd1, 2'd0, 1'b1, 1'b1));

    for (int c = 0; c <= 64; c++) begin
      foreach (tab[k]) begin
        if (tab[k].cyc == cyc) cmp_obs("vector", dut_obs(), tab[k].exp);
      end
      if (c < 64) begin
        load_valid = (cyc == 3);
        digits_in  = 16'h4321;
        step();
      end
    end

    // Second offer while pending is ignored; the reissued word commits one frame later.
    load1(16'hFA98);
    idle_to(66);
    load1(16'h9999);
    chk("ready_low_pending", int'(load_ready), 0);
    idle_to(96);
    chk("commit_fs", int'(frame_start), 1);
    chk("shadow_kept", int'(bcd_out), 8);
    load_hold(16'h9999);
    idle_to(120);
    chk("code_f_forwarded", int'(bcd_out), 15);
    chk("idx3", int'(digit_idx), 3);
    idle_to(128);
    chk("reissue_commit", int'(bcd_out), 9);

    // Display disabled for a whole frame: scan and commit carry on.
    en = 1'b0;
    load1(16'h1357);
    idle_to(140);
    chk("en0_an", int'(an_n), 15);
    chk("en0_idx", int'(digit_idx), 1);
    idle_to(160);
    chk("en0_commit", int'(bcd_out), 7);
    chk("en0_fs", int'(frame_start), 1);
    chk("en0_an_wrap", int'(an_n), 15);
    en = 1'b1;

    // Reset mid-frame discards the pending word and restarts the slot counter.
    load1(16'h2468);
    idle_to(180);
    chk("pending_before_rst", int'(load_ready), 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    cmp_obs("after_rst", dut_obs(), obs_t'({4'b1111, 4'd0, 2'd0, 1'b1, 1'b0}));
    idle_to(182);
    chk("rst_blank", int'(an_n), 15);
    idle_to(183);
    chk("rst_cnt_restart", int'(an_n), 14);
    idle_to(188);
    chk("rst_idx_hold", int'(digit_idx), 0);
    idle_to(189);
    chk("rst_idx_adv", int'(digit_idx), 1);
    idle_to(213);
    chk("rst_wrap_fs", int'(frame_start), 1);
    chk("rst_discard", int'(bcd_out), 0);

    // Leading-zero pattern 0050 and then an all-zero word.
    load1(16'h0050);
    idle_to(245);
    chk("lz_fs", int'(frame_start), 1);
    idle_to(247);
    chk("lz_d0_an", int'(an_n), 14);
    chk("lz_d0_bcd", int'(bcd_out), 0);
    load1(16'h0000);
    idle_to(255);
    chk("lz_d1_an", int'(an_n), 13);
    chk("lz_d1_bcd", int'(bcd_out), 5);
    idle_to(263);
    chk("lz_d2_an", int'(an_n), LZB ? 15 : 11);
    idle_to(271);
    chk("lz_d3_an", int'(an_n), LZB ? 15 : 7);
    idle_to(279);
    chk("zero_d0_an", int'(an_n), 14);
    chk("zero_d0_bcd", int'(bcd_out), 0);
    idle_to(287);
    chk("zero_d1_an", int'(an_n), LZB ? 15 : 13);
    idle_to(290);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
